fetch_unit2: RTL and testbench

FETCH_UNIT2 -- requirements
Module: fetch_unit2

---
 rtl/fetch_unit2_if.sv | 51 +++++
 rtl/fetch_unit2.sv | 150 +++++++++++++++
 tb/tb_fetch_unit2.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit2_if.sv
// Bundles the fetch unit's memory port, instruction queue, branch bus and flush.
// master: the fetch unit itself; slave: the surrounding core and memory.
// Queue occupancy width follows QDEPTH and must match the fetch unit's parameter.
interface fetch_unit2_if #(
  parameter int QDEPTH = 8
);
  // instruction memory port
  logic                      mem_read;
  logic [31:0]               mem_address;
  logic [31:0]               mem_rdata;
  logic                      mem_resp;
  // instruction queue head
  logic                      deq;
  logic                      q_empty;
  logic [$clog2(QDEPTH):0]   q_count;
  logic [31:0]               inst_out;
  logic [31:0]               pc_out;
  logic [31:0]               pred_next_out;
  // resolved branch bus
  logic                      br_valid;
  logic [31:0]               br_pc;
  logic [31:0]               br_target;
  logic                      br_taken;
  logic                      br_is_jump;
  logic [31:0]               br_pred_next;
  logic                      mispredict;
  logic [31:0]               restart_pc;
  // ROB flush
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;

  modport master (
    output mem_read, mem_address,
    input  mem_rdata, mem_resp,
    input  deq,
    output q_empty, q_count, inst_out, pc_out, pred_next_out,
    input  br_valid, br_pc, br_target, br_taken, br_is_jump, br_pred_next,
    output mispredict, restart_pc,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_read, mem_address,
    output mem_rdata, mem_resp,
    output deq,
    input  q_empty, q_count, inst_out, pc_out, pred_next_out,
    output br_valid, br_pc, br_target, br_taken, br_is_jump, br_pred_next,
    input  mispredict, restart_pc,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit2.sv
// Instruction fetch: predicted-PC fetch into a circular instruction queue, tagless BTB + 2-bit counters.
// Latency: 2 cycles minimum per fetched instruction (issue cycle, then response cycle).
// Backpressure: no request is issued while the queue is full; an issued request is held until mem_resp.
module fetch_unit2 #(
  parameter int          QDEPTH      = 8,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0060
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit2_if.master bus
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DISCARD} state_t;

  state_t         state, state_nxt;
  logic [31:0]    pc, mar;
  logic           issue, enq, deq_do;

  // predictor state
  logic [1:0]             ctr       [BHT_ENTRIES];
  logic [31:0]            btb_tgt   [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] btb_valid;
  logic [IW-1:0]          mar_idx, br_idx;
  logic [31:0]            pred_nxt, actual_next;
  logic                   br_redirects;

  // instruction queue storage
  logic [31:0]    q_inst [QDEPTH];
  logic [31:0]    q_pc   [QDEPTH];
  logic [31:0]    q_pred [QDEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;

  // Prediction for the address in flight; registered arrays give old data on a same-cycle update.
  assign mar_idx  = mar[IW+1:2];
  assign pred_nxt = (btb_valid[mar_idx] && ctr[mar_idx][1]) ? btb_tgt[mar_idx] : mar + 32'd4;

  // Resolved branch outcome.
  assign br_idx       = bus.br_pc[IW+1:2];
  assign br_redirects = bus.br_is_jump | bus.br_taken;
  assign actual_next  = br_redirects ? bus.br_target : bus.br_pc + 32'd4;
  assign bus.mispredict = bus.br_valid && (actual_next != bus.br_pred_next);
  assign bus.restart_pc = bus.br_valid ? actual_next : 32'd0;

  // Memory port: a request is outstanding in WAIT and DISCARD.
  assign bus.mem_read    = (state != REQ);
  assign bus.mem_address = mar;

  // Queue head; zeros when nothing is queued.
  assign bus.q_empty       = (count == '0);
  assign bus.q_count       = count;
  assign bus.inst_out      = bus.q_empty ? 32'd0 : q_inst[head];
  assign bus.pc_out        = bus.q_empty ? 32'd0 : q_pc[head];
  assign bus.pred_next_out = bus.q_empty ? 32'd0 : q_pred[head];
  assign deq_do            = bus.deq && (count != '0);

  // Next-state and fetch control decode.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    enq       = 1'b0;
    case (state)
      REQ: begin
        // a flush in REQ just retargets pc; issue resumes next cycle
        if (!bus.redirect_valid && (count != FULL)) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp) begin
          enq       = !bus.redirect_valid;
          state_nxt = REQ;
        end else if (bus.redirect_valid) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        // a flush here only moves pc; the stale response still closes out the request
        if (bus.mem_resp) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // State, fetch PC and memory address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC;
      mar   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (issue) mar <= pc;
      if (bus.redirect_valid) pc <= bus.redirect_pc;
      else if (enq)           pc <= pred_nxt;
    end
  end

  // Saturating 2-bit counters and BTB valid bits, trained by resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= 2'b01;
      btb_valid <= '0;
    end else if (bus.br_valid) begin
      if (bus.br_is_jump)                         ctr[br_idx] <= 2'b11;
      else if (bus.br_taken && ctr[br_idx] != 2'b11)  ctr[br_idx] <= ctr[br_idx] + 2'b01;
      else if (!bus.br_taken && ctr[br_idx] != 2'b00) ctr[br_idx] <= ctr[br_idx] - 2'b01;
      if (br_redirects) btb_valid[br_idx] <= 1'b1;
    end
  end

  // BTB targets need no reset: each is guarded by its valid bit.
  always_ff @(posedge clk) begin
    if (bus.br_valid && br_redirects) btb_tgt[br_idx] <= {bus.br_target[31:2], 2'b00};
  end

  // Queue pointers and occupancy; a flush empties the queue and wins over enq/deq.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)    tail <= tail + PW'(1);
      if (deq_do) head <= head + PW'(1);
      case ({enq, deq_do})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload write; the issue gate keeps this from landing on a live entry.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      q_inst[tail] <= bus.mem_rdata;
      q_pc[tail]   <= mar;
      q_pred[tail] <= pred_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit2.sv
// Bench for fetch_unit2: scenario tasks with a memory responder and an expected-entry scoreboard.
// Expected queue entries are pushed when a scenario sets up its fetches and popped on dequeue.
// Inputs are driven and outputs sampled 1 ns after the falling clock edge.
`timescale 1ns/1ps
module tb_fetch_unit2;
  localparam int QDEPTH = 8;
  localparam int BHT    = 64;
  localparam int CW     = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        jump;
    logic [31:0] pred;
    logic        exp_mis;
    logic [31:0] exp_restart;
  } br_row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit2_if #(.QDEPTH(QDEPTH)) bus();

  fetch_unit2 #(.QDEPTH(QDEPTH), .BHT_ENTRIES(BHT), .RESET_PC(32'h0000_0060)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  ent_t        exp_q  [$];
  logic [31:0] served [$];

  // memory model
  bit mem_auto   = 1'b0;
  int resp_delay = 1;
  int wcnt       = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // respond after resp_delay cycles of an outstanding request
  always @(negedge clk) begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'd0;
    if (!rst && mem_auto && bus.mem_read) begin
      wcnt++;
      if (wcnt >= resp_delay) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_address);
        served.push_back(bus.mem_address);
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input bit auto_on, input int delay);
    rst = 1'b1;
    mem_auto = 1'b0;
    bus.deq = 1'b0;
    bus.br_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    step(2);
    served.delete();
    exp_q.delete();
    resp_delay = delay;
    mem_auto = auto_on;
    rst = 1'b0;
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] pred);
    ent_t e;
    e.inst = mem_word(pc);
    e.pc   = pc;
    e.pred = pred;
    return e;
  endfunction

  // pop n entries as the queue presents them, comparing each against the scoreboard
  task automatic drain(input int n, input string tag);
    int got = 0;
    int budget = 0;
    ent_t e;
    while (got < n && budget < 400) begin
      if (!bus.q_empty && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.inst_out !== e.inst || bus.pc_out !== e.pc || bus.pred_next_out !== e.pred)
          $display("FAIL %s entry %0d: got inst=%h pc=%h pred=%h, expected inst=%h pc=%h pred=%h",
                   tag, got, bus.inst_out, bus.pc_out, bus.pred_next_out, e.inst, e.pc, e.pred);
        else n_pass++;
        bus.deq = 1'b1;
        got++;
      end else begin
        bus.deq = 1'b0;
      end
      step();
      budget++;
    end
    bus.deq = 1'b0;
    if (got < n) begin
      n_checks++;
      $display("FAIL %s timeout: popped %0d, expected %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_auto = 1'b0;
    bus.deq = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_pc = 32'h0; bus.br_target = 32'h0; bus.br_taken = 1'b0;
    bus.br_is_jump = 1'b0; bus.br_pred_next = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    step(3);
    n_checks++; if (bus.q_empty !== 1'b1) $display("FAIL reset_q_empty: got %b expected 1", bus.q_empty); else n_pass++;
    n_checks++; if (bus.q_count !== '0) $display("FAIL reset_q_count: got %0d expected 0", bus.q_count); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b expected 0", bus.mem_read); else n_pass++;
    n_checks++; if (bus.inst_out !== 32'h0) $display("FAIL reset_inst_out: got %h expected 0", bus.inst_out); else n_pass++;
    n_checks++; if (bus.pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h expected 0", bus.pc_out); else n_pass++;
    n_checks++; if (bus.pred_next_out !== 32'h0) $display("FAIL reset_pred_out: got %h expected 0", bus.pred_next_out); else n_pass++;
    n_checks++; if (bus.mispredict !== 1'b0) $display("FAIL reset_mispredict: got %b expected 0", bus.mispredict); else n_pass++;
    n_checks++; if (bus.restart_pc !== 32'h0) $display("FAIL reset_restart_pc: got %h expected 0", bus.restart_pc); else n_pass++;
  endtask

  task automatic test_fill();
    do_reset(1'b1, 1);
    step(2 * QDEPTH - 1);
    n_checks++; if (bus.q_count !== QFULL - CW'(1) || bus.mem_read !== 1'b1)
      $display("FAIL fill_cadence: got count=%0d mem_read=%b expected count=%0d mem_read=1", bus.q_count, bus.mem_read, QDEPTH - 1);
    else n_pass++;
    step(3);
    n_checks++; if (bus.q_count !== QFULL) $display("FAIL fill_count: got %0d expected %0d", bus.q_count, QDEPTH); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL fill_stall: got mem_read=%b expected 0", bus.mem_read); else n_pass++;
    n_checks++; if (served.size() != QDEPTH) $display("FAIL fill_fetches: got %0d expected %0d", served.size(), QDEPTH); else n_pass++;
    for (int i = 0; i < QDEPTH && i < served.size(); i++) begin
      n_checks++;
      if (served[i] !== 32'h60 + 32'(4 * i)) $display("FAIL fill_addr%0d: got %h expected %h", i, served[i], 32'h60 + 32'(4 * i));
      else n_pass++;
    end
    for (int i = 0; i < QDEPTH; i++) exp_q.push_back(mk(32'h60 + 32'(4 * i), 32'h64 + 32'(4 * i)));
    drain(QDEPTH, "fill_order");
  endtask

  task automatic test_branch();
    br_row_t rows [4];
    rows[0] = '{32'h60, 32'h100, 1'b1, 1'b0, 32'h64,  1'b1, 32'h100};
    rows[1] = '{32'h80, 32'h200, 1'b0, 1'b0, 32'h84,  1'b0, 32'h84};
    rows[2] = '{32'h80, 32'h200, 1'b0, 1'b0, 32'h200, 1'b1, 32'h84};
    rows[3] = '{32'hA0, 32'h300, 1'b0, 1'b1, 32'h300, 1'b0, 32'h300};
    do_reset(1'b0, 1);
    step(1);
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h60)
      $display("FAIL branch_first_req: got mem_read=%b addr=%h expected 1 / 00000060", bus.mem_read, bus.mem_address);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.br_valid = 1'b1;
      bus.br_pc = rows[i].pc; bus.br_target = rows[i].target; bus.br_taken = rows[i].taken;
      bus.br_is_jump = rows[i].jump; bus.br_pred_next = rows[i].pred;
      #1;
      n_checks++; if (bus.mispredict !== rows[i].exp_mis || bus.restart_pc !== rows[i].exp_restart)
        $display("FAIL branch_row%0d: got mis=%b restart=%h expected mis=%b restart=%h", i, bus.mispredict, bus.restart_pc, rows[i].exp_mis, rows[i].exp_restart);
      else n_pass++;
      step(1);
    end
    bus.br_valid = 1'b0;
    #1;
    n_checks++; if (bus.mispredict !== 1'b0 || bus.restart_pc !== 32'h0)
      $display("FAIL branch_idle: got mis=%b restart=%h expected 0 / 0", bus.mispredict, bus.restart_pc);
    else n_pass++;
    // refetch 0x60: now predicted taken to 0x100
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h60;
    step(1);
    bus.redirect_valid = 1'b0;
    exp_q.push_back(mk(32'h60, 32'h100));
    exp_q.push_back(mk(32'h100, 32'h104));
    mem_auto = 1'b1;
    drain(2, "branch_pred");
    n_checks++; if (served.size() < 3 || served[1] !== 32'h60 || served[2] !== 32'h100)
      $display("FAIL branch_fetch_seq: got %0d fetches, expected 0x60 then 0x100 after the dropped one", served.size());
    else n_pass++;
  endtask

  task automatic test_discard();
    int budget = 0;
    do_reset(1'b0, 3);
    step(1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step(1);
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h60 || bus.q_empty !== 1'b1)
      $display("FAIL discard_hold: got mem_read=%b addr=%h empty=%b expected 1 / 00000060 / 1", bus.mem_read, bus.mem_address, bus.q_empty);
    else n_pass++;
    mem_auto = 1'b1;
    while (served.size() == 0 && budget < 20) begin step(1); budget++; end
    step(1);
    n_checks++; if (bus.mem_read !== 1'b0 || bus.q_empty !== 1'b1)
      $display("FAIL discard_drop: got mem_read=%b empty=%b expected 0 / 1", bus.mem_read, bus.q_empty);
    else n_pass++;
    step(1);
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h200)
      $display("FAIL discard_next_addr: got mem_read=%b addr=%h expected 1 / 00000200", bus.mem_read, bus.mem_address);
    else n_pass++;
    exp_q.push_back(mk(32'h200, 32'h204));
    drain(1, "discard_entry");
  endtask

  task automatic test_redirect_resp();
    do_reset(1'b1, 1);
    step(1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h400;
    step(1);
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.q_empty !== 1'b1 || bus.q_count !== '0 || bus.mem_read !== 1'b0)
      $display("FAIL redir_resp_drop: got empty=%b count=%0d mem_read=%b expected 1 / 0 / 0", bus.q_empty, bus.q_count, bus.mem_read);
    else n_pass++;
    step(1);
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h400)
      $display("FAIL redir_resp_next: got mem_read=%b addr=%h expected 1 / 00000400", bus.mem_read, bus.mem_address);
    else n_pass++;
    exp_q.push_back(mk(32'h400, 32'h404));
    drain(1, "redir_resp_entry");
  endtask

  task automatic test_full_wrap();
    int budget = 0;
    ent_t e;
    do_reset(1'b1, 1);
    while (bus.q_count !== QFULL && budget < 100) begin step(1); budget++; end
    for (int i = 0; i < 2 * QDEPTH; i++) exp_q.push_back(mk(32'h60 + 32'(4 * i), 32'h64 + 32'(4 * i)));
    e = exp_q.pop_front();
    n_checks++; if (bus.pc_out !== e.pc || bus.inst_out !== e.inst || bus.pred_next_out !== e.pred)
      $display("FAIL wrap_head: got pc=%h inst=%h pred=%h expected pc=%h inst=%h pred=%h", bus.pc_out, bus.inst_out, bus.pred_next_out, e.pc, e.inst, e.pred);
    else n_pass++;
    bus.deq = 1'b1;
    step(1);
    bus.deq = 1'b0;
    n_checks++; if (bus.mem_read !== 1'b0 || bus.q_count !== QFULL - CW'(1))
      $display("FAIL wrap_no_issue: got mem_read=%b count=%0d expected 0 / %0d", bus.mem_read, bus.q_count, QDEPTH - 1);
    else n_pass++;
    step(1);
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h60 + 32'(4 * QDEPTH))
      $display("FAIL wrap_issue: got mem_read=%b addr=%h expected 1 / %h", bus.mem_read, bus.mem_address, 32'h60 + 32'(4 * QDEPTH));
    else n_pass++;
    drain(2 * QDEPTH - 1, "wrap_order");
  endtask

  task automatic test_counter();
    do_reset(1'b0, 1);
    step(1);
    // jump then one not-taken: 01 -> 11 -> 10, still predicted taken
    bus.br_valid = 1'b1; bus.br_pc = 32'h60; bus.br_target = 32'h140;
    bus.br_is_jump = 1'b1; bus.br_taken = 1'b0; bus.br_pred_next = 32'h64;
    step(1);
    bus.br_is_jump = 1'b0;
    step(1);
    bus.br_valid = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h60;
    step(1);
    bus.redirect_valid = 1'b0;
    exp_q.push_back(mk(32'h60, 32'h140));
    mem_auto = 1'b1;
    drain(1, "ctr_after_jump");
    mem_auto = 1'b0;
    step(3);
    // second not-taken: 10 -> 01, back to fall-through
    bus.br_valid = 1'b1;
    step(1);
    bus.br_valid = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h60;
    step(1);
    bus.redirect_valid = 1'b0;
    exp_q.push_back(mk(32'h60, 32'h64));
    mem_auto = 1'b1;
    drain(1, "ctr_after_two_nt");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_branch();
    test_discard();
    test_redirect_resp();
    test_full_wrap();
    test_counter();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
